// File: rtl/regfile_pkg.sv
// Shared constants for the decode-stage register file with scoreboard.
// Default widths, sweep FSM state encoding and the hardwired-zero address.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int REG_ZERO = 0;

    typedef enum logic {
        S_INIT = ST_INIT,
        S_RUN  = ST_RUN
    } state_e;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode-side bundle of the register file: read, writeback and issue ports.
// master = decode/writeback/issue logic, slave = regfile_sb.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     ready;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, ready
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write (busy) bit per register; issue sets, writeback clears.
// Ports: clk, rst_n, set_en_i/set_addr_i, clr_en_i/clr_addr_i, busy_next_o.
module regfile_sb_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    localparam int DEPTH = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    output logic [DEPTH-1:0]  busy_next_o
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clr_mask;

    // Set is OR-ed after the clear so a same-cycle reissue stays pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i && set_addr_i != ZERO_A)
            set_mask[set_addr_i] = 1'b1;
        if (clr_en_i && clr_addr_i != ZERO_A)
            clr_mask[clr_addr_i] = 1'b1;
        busy_next_o = (busy_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_next_o;
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file: NUM_RD registered read ports, bypassed write, zero reg,
// busy scoreboard, post-reset clearing sweep. Ports: clk, rst_n, bus (slave).
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              run;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [DEPTH-1:0]  busy_next;

    // No reset on the array; the INIT sweep clears it instead.
    logic [DATA_W-1:0] mem [DEPTH];

    assign run       = (state_q == S_RUN);
    assign bus.ready = run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_we  = 1'b0;
        mem_wa  = bus.wr_addr;
        mem_wd  = bus.wr_data;
        unique case (state_q)
            S_INIT: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = '0;
                cnt_d  = cnt_q + ADDR_W'(1);
                if (&cnt_q)
                    state_d = S_RUN;
            end
            S_RUN: begin
                mem_we = bus.wr_en && bus.wr_addr != ZERO_A;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    regfile_sb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .set_en_i    (run && bus.iss_en),
        .set_addr_i  (bus.iss_addr),
        .clr_en_i    (run && bus.wr_en),
        .clr_addr_i  (bus.wr_addr),
        .busy_next_o (busy_next)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_d;
        logic [DATA_W-1:0] d_q;
        logic              b_q;

        assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

        // Zero register wins over the bypass, bypass wins over the array.
        always_comb begin
            rd_d = mem[ra];
            if (bus.wr_en && bus.wr_addr == ra)
                rd_d = bus.wr_data;
            if (ra == ZERO_A)
                rd_d = '0;
        end

        always_ff @(posedge clk) begin
            if (!rst_n || !run) begin
                d_q <= '0;
                b_q <= 1'b0;
            end else begin
                d_q <= rd_d;
                b_q <= busy_next[ra];
            end
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = d_q;
        assign bus.rd_busy[k]                  = b_q;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: reference model feeds a queue of
// expected read results, popped one cycle after each stimulus beat.
module tb_regfile_sb;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_sb_if bus ();

    regfile_sb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        q[$];
    logic [31:0] mem_m [32];
    logic [31:0] busy_m;
    int          total = 0;
    int          bad = 0;

    task automatic idle();
        bus.rd_addr  = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
    endtask

    // Drive one RUN beat, predict its registered result, push it.
    task automatic step(input logic [4:0] a0, input logic [4:0] a1,
                        input logic we, input logic [4:0] wa,
                        input logic [31:0] wd,
                        input logic ie, input logic [4:0] ia);
        exp_t        e;
        logic [31:0] bn;
        logic [4:0]  ra [2];
        @(negedge clk);
        bus.rd_addr  = {a1, a0};
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.iss_en   = ie;
        bus.iss_addr = ia;
        ra[0] = a0;
        ra[1] = a1;
        bn = busy_m;
        if (we && wa != 0) bn[wa] = 1'b0;
        if (ie && ia != 0) bn[ia] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (ra[k] == 0)
                e.d[k*32 +: 32] = 32'h0;
            else if (we && wa == ra[k])
                e.d[k*32 +: 32] = wd;
            else
                e.d[k*32 +: 32] = mem_m[ra[k]];
            e.b[k] = bn[ra[k]];
        end
        if (we && wa != 0) mem_m[wa] = wd;
        busy_m = bn;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_init_sweep(input string nm);
        exp_t e;
        @(negedge clk);
        bus.rd_addr  = {5'd4, 5'd3};
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'd3;
        bus.wr_data  = 32'hAAAA5555;
        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'd4;
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.ready !== (i == 32) || bus.rd_data !== 64'h0 ||
                bus.rd_busy !== 2'b00) begin
                bad++;
                $display("FAIL %s_sweep cyc=%0d: ready=%b data=%h busy=%b want ready=%b data=0 busy=0",
                         nm, i, bus.ready, bus.rd_data, bus.rd_busy, i == 32);
            end
        end
        for (int a = 0; a < 32; a++) mem_m[a] = 32'h0;
        busy_m = '0;
        for (int a = 0; a < 16; a++) begin
            step(5'(a), 5'(31 - a), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            e = q.pop_front();
            total++;
            if (bus.rd_data !== e.d || bus.rd_busy !== e.b) begin
                bad++;
                $display("FAIL %s_clear a=%0d: data=%h busy=%b want data=%h busy=%b",
                         nm, a, bus.rd_data, bus.rd_busy, e.d, e.b);
            end
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.ready !== 1'b0 || bus.rd_data !== 64'h0 ||
            bus.rd_busy !== 2'b00) begin
            bad++;
            $display("FAIL reset: ready=%b data=%h busy=%b want 0/0/0",
                     bus.ready, bus.rd_data, bus.rd_busy);
        end
        test_init_sweep("init");
    endtask

    task automatic test_write_read();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: step(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
                1: step(5'd5, 5'd1, 1'b1, 5'd1, 32'h00C0FFEE, 1'b0, 5'd0);
                default: step(5'd5, 5'd1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            endcase
            e = q.pop_front();
            total++;
            if (bus.rd_data !== e.d || bus.rd_busy !== e.b) begin
                bad++;
                $display("FAIL write_read %0d: data=%h busy=%b want data=%h busy=%b",
                         i, bus.rd_data, bus.rd_busy, e.d, e.b);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: step(5'd0, 5'd0, 1'b1, 5'd7, 32'h00001111, 1'b0, 5'd0);
                1: step(5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
                2: step(5'd7, 5'd7, 1'b1, 5'd7, 32'h00001234, 1'b0, 5'd0);
                default: step(5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            endcase
            e = q.pop_front();
            total++;
            if (bus.rd_data !== e.d || bus.rd_busy !== e.b) begin
                bad++;
                $display("FAIL bypass %0d: data=%h busy=%b want data=%h busy=%b",
                         i, bus.rd_data, bus.rd_busy, e.d, e.b);
            end
        end
    endtask

    task automatic test_zero();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: step(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
                1: step(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
                default: step(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            endcase
            e = q.pop_front();
            total++;
            if (bus.rd_data !== e.d || bus.rd_busy !== e.b) begin
                bad++;
                $display("FAIL zero %0d: data=%h busy=%b want data=%h busy=%b",
                         i, bus.rd_data, bus.rd_busy, e.d, e.b);
            end
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: step(5'd9, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
                1: step(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
                2: step(5'd9, 5'd9, 1'b1, 5'd9, 32'h00000099, 1'b0, 5'd0);
                3: step(5'd9, 5'd9, 1'b1, 5'd9, 32'h000000AA, 1'b1, 5'd9);
                4: step(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
                default: step(5'd9, 5'd9, 1'b1, 5'd9, 32'h000000BB, 1'b0, 5'd0);
            endcase
            e = q.pop_front();
            total++;
            if (bus.rd_data !== e.d || bus.rd_busy !== e.b) begin
                bad++;
                $display("FAIL scoreboard %0d: data=%h busy=%b want data=%h busy=%b",
                         i, bus.rd_data, bus.rd_busy, e.d, e.b);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 $urandom, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)));
            e = q.pop_front();
            total++;
            if (bus.rd_data !== e.d || bus.rd_busy !== e.b) begin
                bad++;
                $display("FAIL b2b %0d: data=%h busy=%b want data=%h busy=%b",
                         i, bus.rd_data, bus.rd_busy, e.d, e.b);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            idle();
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            total++;
            if (bus.ready !== 1'b0 || bus.rd_data !== 64'h0 ||
                bus.rd_busy !== 2'b00) begin
                bad++;
                $display("FAIL reset_mid %0d: ready=%b data=%h busy=%b want 0/0/0",
                         r, bus.ready, bus.rd_data, bus.rd_busy);
            end
            if (r == 0) begin
                @(negedge clk);
                rst_n = 1'b1;
                repeat (10) @(posedge clk);
            end
        end
        test_init_sweep("mid");
    endtask

    initial begin
        busy_m = '0;
        for (int a = 0; a < 32; a++) mem_m[a] = 32'h0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero();
        test_scoreboard();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
